cdc_tx_queue: RTL and testbench

//  Byte queue between the CDC receive port (recv_data/recv_valid) and the CDC send port
//  (send_data/send_valid/send_ready) of usb_serial_top, clocked by clk60.

---
 rtl/cube_pkg.sv | 17 +
 rtl/cdc_tx_queue_if.sv | 27 ++
 rtl/cdc_tx_queue_ram.sv | 25 ++
 rtl/cdc_tx_queue.sv | 121 ++++++++++++
 tb/tb_cdc_tx_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cube_pkg.sv
// Shared console constants and character helpers used across the cube console blocks.
package cube_pkg;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
      r = b - ASCII_CASE_OFS;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_tx_queue_if.sv
// Byte stream into and out of the CDC loopback queue.
// The master side produces bytes and accepts the head; the slave side is the queue.
interface cdc_tx_queue_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/cdc_tx_queue_ram.sv
// Simple dual-port byte storage: one write port, one registered read port, no reset.
module cdc_tx_queue_ram #(
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [7:0] mem_q [Depth];

  // Read-before-write on an address collision; the top never relies on write-through.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cdc_tx_queue.sv
// Byte queue between the CDC receive and send ports in the clk60 domain, with optional
// upper-casing on write and a saturating count of bytes dropped on overflow.
module cdc_tx_queue
  import cube_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned UPCASE     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  cdc_tx_queue_if.slave         bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_cnt
);

  typedef logic [DEPTH_LOG2:0] ptr_t;

  localparam ptr_t             PtrOne = ptr_t'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_byp_q, sel_byp_d;
  logic [7:0]       byp_q, byp_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]       wr_byte;
  logic [7:0]       ram_rdata;
  logic             push, pop, drop;

  assign wr_byte = (UPCASE != 0) ? to_upper(bus.in_data) : bus.in_data;

  assign full = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign pop  = out_valid_q & bus.out_ready & ~flush;
  assign push = bus.in_valid & (~full | pop) & ~flush;
  assign drop = bus.in_valid & full & ~pop & ~flush;

  // rd_ptr addresses the head entry. The RAM is read at the next head address every cycle;
  // when that entry is being written in the same cycle, the head is taken from byp_q.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sel_byp_d  = sel_byp_q;
    byp_d      = byp_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        sel_byp_d = 1'b1;
        byp_d     = wr_byte;
      end else if (pop) begin
        sel_byp_d = 1'b0;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CntOne;
        end
      end
    end
    level_d     = wr_ptr_d - rd_ptr_d;
    out_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      sel_byp_q   <= 1'b1;
      byp_q       <= 8'h00;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      sel_byp_q   <= sel_byp_d;
      byp_q       <= byp_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  cdc_tx_queue_ram #(
    .AddrW (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_byte),
    .raddr_i (rd_ptr_d[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = sel_byp_q ? byp_q : ram_rdata;
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_cdc_tx_queue.sv
// Directed bench for cdc_tx_queue: vector table for single-cycle behaviour, hand sequences
// for fill/overflow/drain, full-with-pop, pointer wrap and asynchronous reset.
module tb_cdc_tx_queue;

  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [DL:0] level;
  logic        full;
  logic        overflow;
  logic [15:0] drop_cnt;

  cdc_tx_queue_if q_if ();

  cdc_tx_queue #(
    .DEPTH_LOG2 (DL),
    .UPCASE     (1),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (q_if.slave),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [DL:0] exp_level;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [7:0] d,
                              input logic rdy, input logic ev, input logic [7:0] ed,
                              input logic [DL:0] el);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.in_data = d; v.out_ready = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_level = el;
    return v;
  endfunction

  function automatic logic [7:0] upper(input logic [7:0] d);
    return (d >= 8'h61 && d <= 8'h7A) ? d - 8'h20 : d;
  endfunction

  logic [7:0] sb [$];
  logic [7:0] exp_b;
  logic       xfer;

  initial begin
    q_if.in_data   = 8'h00;
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b0;

    // Single-lane stream, upper-casing, registered latency, flush with in_valid.
    vecs[0]  = mk(1'b0, 1'b1, 8'h61, 1'b1, 1'b1, 8'h41, 5'd1);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0);
    vecs[2]  = mk(1'b0, 1'b1, 8'h60, 1'b1, 1'b1, 8'h60, 5'd1);
    vecs[3]  = mk(1'b0, 1'b1, 8'h7A, 1'b1, 1'b1, 8'h5A, 5'd1);
    vecs[4]  = mk(1'b0, 1'b1, 8'h7B, 1'b1, 1'b1, 8'h7B, 5'd1);
    vecs[5]  = mk(1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 8'h30, 5'd1);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0);
    vecs[7]  = mk(1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 5'd1);
    vecs[8]  = mk(1'b0, 1'b1, 8'h62, 1'b0, 1'b1, 8'h41, 5'd2);
    vecs[9]  = mk(1'b0, 1'b1, 8'h63, 1'b1, 1'b1, 8'h42, 5'd2);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 5'd1);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0);
    vecs[12] = mk(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 5'd1);
    vecs[13] = mk(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 5'd2);
    vecs[14] = mk(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 5'd3);
    vecs[15] = mk(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 5'd4);
    vecs[16] = mk(1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 5'd5);
    vecs[17] = mk(1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 8'h00, 5'd0);
    vecs[18] = mk(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 5'd1);
    vecs[19] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0);

    tick();
    tick();
    chk("reset out_valid", 32'(q_if.out_valid), 32'd0);
    chk("reset out_data", 32'(q_if.out_data), 32'h00);
    chk("reset level", 32'(level), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      flush          = vecs[i].flush;
      q_if.in_valid  = vecs[i].in_valid;
      q_if.in_data   = vecs[i].in_data;
      q_if.out_ready = vecs[i].out_ready;
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(q_if.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d out_data", i), 32'(q_if.out_data), 32'(vecs[i].exp_data));
      end
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'd0);
    end
    flush = 1'b0;

    // Overfill with the sink stalled, then drain without bubbles.
    q_if.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = 8'(i);
      tick();
    end
    q_if.in_valid = 1'b0;
    chk("overfill level", 32'(level), 32'(DEPTH));
    chk("overfill full", 32'(full), 32'd1);
    chk("overfill drop_cnt", 32'(drop_cnt), 32'd2);
    chk("overfill overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain valid", 32'(q_if.out_valid), 32'd1);
      chk("drain data", 32'(q_if.out_data), 32'(i));
      q_if.out_ready = 1'b1;
      tick();
    end
    chk("drain end valid", 32'(q_if.out_valid), 32'd0);
    chk("drain end level", 32'(level), 32'd0);
    chk("drain end full", 32'(full), 32'd0);

    // Full with a simultaneous pop accepts the byte; full without pop drops it.
    q_if.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = 8'h20 + 8'(i);
      tick();
    end
    chk("refill full", 32'(full), 32'd1);
    q_if.in_data   = 8'h55;
    q_if.out_ready = 1'b1;
    tick();
    chk("full+pop level", 32'(level), 32'(DEPTH));
    chk("full+pop full", 32'(full), 32'd1);
    chk("full+pop drop_cnt", 32'(drop_cnt), 32'd2);
    chk("full+pop head", 32'(q_if.out_data), 32'h21);
    q_if.in_data   = 8'h56;
    q_if.out_ready = 1'b0;
    tick();
    chk("full drop drop_cnt", 32'(drop_cnt), 32'd3);
    chk("full drop level", 32'(level), 32'(DEPTH));
    q_if.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h21 + 8'(i) : 8'h55;
      chk("full+pop drain valid", 32'(q_if.out_valid), 32'd1);
      chk("full+pop drain data", 32'(q_if.out_data), 32'(exp_b));
      q_if.out_ready = 1'b1;
      tick();
    end
    chk("full+pop drain end", 32'(q_if.out_valid), 32'd0);

    // Pointer wrap: strobes on even cycles, sink ready on odd cycles, against a scoreboard.
    for (int c = 0; c < 90; c++) begin
      chk("wrap valid", 32'(q_if.out_valid), 32'(sb.size() != 0));
      q_if.in_valid  = (c < 80) && (c % 2 == 0);
      q_if.in_data   = 8'h50 + 8'(c / 2);
      q_if.out_ready = (c % 2 == 1) || (c >= 80);
      xfer = q_if.out_valid && q_if.out_ready;
      if (xfer) begin
        if (sb.size() == 0) begin
          chk("wrap spurious valid", 32'(q_if.out_valid), 32'd0);
        end else begin
          exp_b = sb.pop_front();
          chk("wrap data", 32'(q_if.out_data), 32'(exp_b));
        end
      end
      if (q_if.in_valid && (sb.size() < DEPTH || xfer)) begin
        sb.push_back(upper(q_if.in_data));
      end
      tick();
    end
    chk("wrap end level", 32'(level), 32'd0);
    chk("wrap drop_cnt", 32'(drop_cnt), 32'd3);

    // Asynchronous reset in the middle of a burst.
    q_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = 8'h41 + 8'(i);
      tick();
    end
    chk("pre-rst level", 32'(level), 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(q_if.out_valid), 32'd0);
    chk("async rst out_data", 32'(q_if.out_data), 32'h00);
    chk("async rst level", 32'(level), 32'd0);
    chk("async rst overflow", 32'(overflow), 32'd0);
    chk("async rst drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b0;
    q_if.in_valid = 1'b1;
    q_if.in_data  = 8'h6B;
    tick();
    q_if.in_valid = 1'b0;
    chk("post-rst valid", 32'(q_if.out_valid), 32'd1);
    chk("post-rst data", 32'(q_if.out_data), 32'h4B);
    chk("post-rst level", 32'(level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
